// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned, WIDTH x WIDTH -> 2*WIDTH.
// Latency: DONE is high in the cycle after the WIDTH-th CALC edge; the accepting edge is edge 1, so DONE is seen after edge WIDTH+1.
// Backpressure: none; START is only accepted in IDLE and ignored while BUSY.
//
// Ports:
//   CLK, RST_N  - clock (rising edge) and asynchronous active-low reset
//   START       - request a multiply; A, B and SIGNED are captured on the same edge
//   SIGNED      - 1: two's-complement operands, 0: unsigned operands
//   A, B        - multiplicand and multiplier
//   HI, LO      - upper and lower halves of the last completed product
//   BUSY        - high in CALC and FIN
//   DONE        - one-cycle pulse in FIN; HI/LO hold a fresh result
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;     // |A|, held for the whole operation
    logic [2*WIDTH-1:0] prod;      // upper half accumulates, lower half shifts out |B|
    logic               neg;       // result must be negated at the end

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               last_step;
    logic               accept;

    // Operand magnitudes. The most-negative value negates to itself, which read
    // as unsigned is exactly its magnitude, so WIDTH bits suffice.
    always_comb begin
        mag_a = A;
        mag_b = B;
        if (SIGNED && A[WIDTH-1]) begin
            mag_a = ~A + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (SIGNED && B[WIDTH-1]) begin
            mag_b = ~B + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (prod[0]) is set, keep the carry, shift right by one.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        prod_step = {step_sum, prod[WIDTH-1:1]};
        prod_fix  = prod_step;
        if (neg) begin
            prod_fix = ~prod_step + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign accept    = (state == IDLE) && START;
    assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            CALC: BUSY = 1'b1;
            FIN: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
                DONE = 1'b0;
            end
        endcase
    end

    // Datapath: operands are captured only on the accepting edge, so later
    // changes on A/B/SIGNED cannot disturb an operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            neg   <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else if (accept) begin
            cnt   <= '0;
            mcand <= mag_a;
            prod  <= {{WIDTH{1'b0}}, mag_b};
            neg   <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
        end else if (state == CALC) begin
            prod <= prod_step;
            cnt  <= last_step ? '0 : cnt + CW'(1);
            // Result registers change only on the CALC -> FIN edge.
            if (last_step) begin
                {HI, LO} <= prod_fix;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sgn;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    logic        start8, sgn8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(32)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .SIGNED(sgn),
        .A(a), .B(b), .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
    );

    mult_seq #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .SIGNED(sgn8),
        .A(a8), .B(b8), .HI(hi8), .LO(lo8), .BUSY(busy8), .DONE(done8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the exact mathematical product, reduced to 2*WIDTH bits.
    function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint px, py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'({32'd0, x});
            py = longint'({32'd0, y});
        end
        return 64'(px * py);
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int px, py;
        px = s ? int'($signed(x)) : int'({24'd0, x});
        py = s ? int'($signed(y)) : int'({24'd0, y});
        return 16'(px * py);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // FIN -> IDLE edge, so back-to-back calls issue at the minimum interval.
    // Edge counting: the accepting edge is edge 1, DONE must be seen after edge 33.
    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s, input string tag);
        logic [63:0] exp;
        logic [63:0] prev;
        int n;
        exp  = model32(x, y, s);
        prev = {hi, lo};
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        check({tag, " busy"}, 64'(busy), 64'd1);
        start = 1'b0;
        while (!done && n < 100) begin
            if (n > 1) check({tag, " hold"}, {hi, lo}, prev);
            a = $urandom; b = $urandom; sgn = 1'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " product"}, {hi, lo}, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle"}, {62'd0, busy, done}, 64'd0);
        check({tag, " keep"}, {hi, lo}, exp);
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
        logic [15:0] exp;
        int n;
        exp = model8(x, y, s);
        a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && n < 50) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        check({tag, " product"}, {48'd0, hi8, lo8}, {48'd0, exp});
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle"}, {62'd0, busy8, done8}, 64'd0);
    endtask

    initial begin
        int n;
        int dones;
        logic [31:0] rx, ry;
        logic [7:0]  rx8, ry8;

        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset32", {hi, lo, 30'd0, busy, done} >> 0, 64'd0);
        check("reset8", {46'd0, hi8, lo8, busy8, done8}, 64'd0);
        rst_n = 1'b1;

        // Directed operand patterns
        run32(32'hFFFFFFFF, 32'h1,        1'b0, "u_ff_x1");
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "u_ff_ff");
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "s_m1_m1");
        run32(32'hFFFFFFFF, 32'h1,        1'b1, "s_m1_x1");
        run32(32'h80000000, 32'h80000000, 1'b1, "s_min_min");
        run32(32'h80000000, 32'h7FFFFFFF, 1'b1, "s_min_max");
        run32(32'h0,        32'hDEADBEEF, 1'b1, "zero_a");
        run32(32'h12345678, 32'h0,        1'b0, "zero_b");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            rx = $urandom; ry = $urandom;
            run32(rx, ry, 1'(i % 2), "rand32");
        end

        // START re-pulsed mid-CALC with new operands must be ignored
        a = 32'd3; b = 32'd3; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(posedge clk); n++; @(negedge clk); end
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); n++;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin @(posedge clk); n++; @(negedge clk); end
        check("restart latency", 64'(n), 64'd33);
        check("restart product", {hi, lo}, 64'd9);
        dones = 0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (done) dones++; end
        check("restart single done", 64'(dones), 64'd0);

        // Reset at CALC step 10 abandons the operation immediately
        a = 32'd7; b = 32'd6; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        check("mid busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst result", {hi, lo}, 64'd0);
        check("rst done", 64'(done), 64'd0);
        start = 1'b1;           // must be ignored while reset is low
        @(posedge clk);
        @(negedge clk);
        check("rst start ignored", 64'(busy), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        run32(32'd2, 32'd2, 1'b0, "after_rst");

        // Narrow instance
        run8(8'hFF, 8'hFF, 1'b0, "w8_ff_ff");
        run8(8'h80, 8'h80, 1'b1, "w8_min_min");
        run8(8'h80, 8'h01, 1'b1, "w8_min_x1");
        for (int i = 0; i < 6; i++) begin
            rx8 = 8'($urandom); ry8 = 8'($urandom);
            run8(rx8, ry8, 1'(i % 2), "rand8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
